// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: redirect/stall controls in, imem address/data, IF/ID register out.
// No latency of its own; it is wiring between fetch_stage and its neighbours.
// No backpressure on this bundle beyond the stall level signal carried here.
//
// Ports (signals):
//   stall, redirect_valid, redirect_pc  : control from decode / execute
//   imem_addr / imem_data               : combinational instruction-memory port
//   id_instr, id_pc_plus4, id_valid     : IF/ID pipeline register contents
//   fetch_count                         : running count of instructions accepted into IF/ID
// Modports: master = fetch stage side, slave = surrounding pipeline / memory side.
interface fetch_stage_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               stall;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc_plus4;
    logic               id_valid;
    logic [15:0]        fetch_count;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_data,
        output imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_data,
        input  imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, presents it to imem, registers the returned word into IF/ID.
// Latency: instruction at pc appears on id_instr one rising edge after pc is presented.
// Backpressure: stall holds PC, IF/ID and fetch_count; a redirect overrides stall and loads a bubble.
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : fetch_stage_if.master (stall/redirect in, imem port, IF/ID register and fetch_count out)
module fetch_stage #(
    parameter int                ADDR_W    = 16,
    parameter int                INSTR_W   = 16,
    parameter int                PC_STEP   = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    // IF/ID pipeline register kept as one packed word so hold/flush act on it as a unit.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_plus4;
        logic               vld;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, vld: 1'b0};

    logic [ADDR_W-1:0] pc_q, pc_d;
    ifid_t             ifid_q, ifid_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic [ADDR_W-1:0] pc_inc;

    // Wraps modulo 2^ADDR_W by construction (0xFFFC + 4 -> 0x0000).
    assign pc_inc = pc_q + STEP;

    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        fcnt_d = fcnt_q;
        if (bus.redirect_valid) begin
            // Redirect wins over stall: the stalled instruction belongs to the squashed path.
            pc_d   = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            ifid_d = IFID_BUBBLE;
        end else if (!bus.stall) begin
            pc_d            = pc_inc;
            ifid_d.instr    = bus.imem_data;
            ifid_d.pc_plus4 = pc_inc;
            ifid_d.vld      = 1'b1;
            fcnt_d          = fcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            ifid_q <= IFID_BUBBLE;
            fcnt_q <= 16'd0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.id_instr    = ifid_q.instr;
    assign bus.id_pc_plus4 = ifid_q.pc_plus4;
    assign bus.id_valid    = ifid_q.vld;
    assign bus.fetch_count = fcnt_q;

endmodule
